// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and ALU bus of the two-port ALU arbiter.
// master = environment (requesters + ALU), slave = arbiter.
interface alu_arbiter_if;
  logic       on;
  logic       req0;
  logic       req1;
  logic [6:0] op0;
  logic [6:0] op1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] result;
  logic       err;
  logic       busy;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_out;
  logic [1:0] state;

  modport master (
    output on, req0, req1,
    output op0, op1, a0, b0, a1, b1,
    output alu_out,
    input  gnt0, gnt1, done0, done1,
    input  result, err, busy, state,
    input  alu_in_sel, alu_num1,
    input  alu_num2, alu_out_sel
  );

  modport slave (
    input  on, req0, req1,
    input  op0, op1, a0, b0, a1, b1,
    input  alu_out,
    output gnt0, gnt1, done0, done1,
    output result, err, busy, state,
    output alu_in_sel, alu_num1,
    output alu_num2, alu_out_sel
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters.
// Ports: clk, rst (async active-low), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } st_t;

  st_t        st;
  st_t        st_nx;
  logic [3:0] cnt;
  logic [6:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] res_q;
  logic       id_q;
  logic       err_q;
  logic       last_q;

  logic       accept;
  logic       pick1;
  logic [6:0] op_w;
  logic [7:0] a_w;
  logic [7:0] b_w;
  logic       op_ok;

  // last_q is the id served last; reset value 1 lets req0 win the first tie
  always_comb begin
    accept = bus.on & (bus.req0 | bus.req1);
    pick1  = bus.req1 & (~bus.req0 | ~last_q);
    op_w   = pick1 ? bus.op1 : bus.op0;
    a_w    = pick1 ? bus.a1 : bus.a0;
    b_w    = pick1 ? bus.b1 : bus.b0;
    op_ok  = (op_w != 7'd0) &&
             ((op_w & (op_w - 7'd1)) == 7'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (accept) st_nx = op_ok ? LOAD : RESP;
      end
      LOAD: st_nx = EXEC;
      EXEC: begin
        if (cnt <= 4'd1) st_nx = RESP;
      end
      RESP: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 4'd0;
      op_q   <= 7'd0;
      a_q    <= 8'd0;
      b_q    <= 8'd0;
      res_q  <= 8'd0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      unique case (st)
        IDLE: begin
          if (accept) begin
            id_q  <= pick1;
            op_q  <= op_w;
            err_q <= ~op_ok;
            // operands only move on a real LOAD
            if (op_ok) begin
              a_q <= a_w;
              b_q <= b_w;
            end else begin
              res_q <= 8'd0;
            end
          end
        end
        LOAD: cnt <= 4'(EXEC_CYCLES);
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) res_q <= bus.alu_out;
        end
        RESP: last_q <= id_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.gnt0        = 1'b0;
    bus.gnt1        = 1'b0;
    bus.done0       = 1'b0;
    bus.done1       = 1'b0;
    bus.err         = 1'b0;
    bus.alu_in_sel  = 3'b000;
    bus.alu_out_sel = 7'd0;
    bus.busy        = (st != IDLE);
    bus.state       = st;
    bus.result      = res_q;
    bus.alu_num1    = a_q;
    bus.alu_num2    = b_q;
    unique case (st)
      LOAD: begin
        bus.alu_in_sel = 3'b010;
        bus.gnt0       = ~id_q;
        bus.gnt1       = id_q;
      end
      EXEC: begin
        bus.alu_in_sel  = 3'b100;
        bus.alu_out_sel = op_q;
      end
      RESP: begin
        bus.done0 = ~id_q;
        bus.done1 = id_q;
        bus.err   = err_q;
        // rejected ops never pass LOAD, so grant here
        bus.gnt0  = err_q & ~id_q;
        bus.gnt1  = err_q & id_q;
      end
      default: ;
    endcase
  end

endmodule
